// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: command opcodes, FSM state
// encoding and frame field lengths.
package boot_loader_pkg;

  // Command opcodes (first byte of every frame)
  localparam logic [7:0] CMD_LOAD_INST = 8'hA5;
  localparam logic [7:0] CMD_LOAD_REG  = 8'h5A;
  localparam logic [7:0] CMD_START     = 8'hC3;

  // Frame field lengths in bytes
  localparam int FIELD_WORD_BYTES  = 4;  // addr / data words
  localparam int FIELD_COUNT_BYTES = 2;  // LOAD_INST word count

  // FSM state encoding
  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_ADDR       = 4'd1;
  localparam logic [3:0] ST_COUNT      = 4'd2;
  localparam logic [3:0] ST_DATA       = 4'd3;
  localparam logic [3:0] ST_WRITE      = 4'd4;
  localparam logic [3:0] ST_REG_ADDR   = 4'd5;
  localparam logic [3:0] ST_REG_DATA   = 4'd6;
  localparam logic [3:0] ST_START_ADDR = 4'd7;
  localparam logic [3:0] ST_DONE       = 4'd8;
  localparam logic [3:0] ST_ERR        = 4'd9;

endpackage

// File: rtl/boot_loader_byte_to_word_assembler.sv
// Little-endian byte-to-word assembler shared by every 32-bit field of the
// boot loader frames.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   byte_en     - a byte of a word field is consumed this cycle
//   byte_data   - the byte being consumed
//   word_done   - this byte completes a word (combinational)
//   next_word   - word value including this cycle's byte (combinational);
//                 the full word when word_done is high
module boot_loader_byte_to_word_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic [31:0] next_word
);

  logic [1:0]  idx;
  logic [31:0] word_q;

  // LSB arrives first, so each new byte enters at the top and the earlier
  // bytes shift down; after four bytes byte 0 sits in bits 7:0.
  assign next_word = {byte_data, word_q[31:8]};
  assign word_done = byte_en && (idx == 2'(FIELD_WORD_BYTES - 1));

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      word_q <= '0;
    end else if (byte_en) begin
      idx    <= idx + 2'd1;  // wraps to 0 after the 4th byte
      word_q <= next_word;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Byte-stream boot loader: parses framed commands from a valid/ready byte
// link and drives instruction-memory writes, register preloads and the PC
// start address, holding the core in setup until a START frame.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   i_byte_valid/data   - input byte stream
//   o_byte_ready        - byte accepted this cycle when valid is high
//   o_setup             - core held in setup/load mode
//   o_inst_mem_we/addr/data - one-cycle instruction word write
//   o_load_reg_we/addr/data - one-cycle register preload
//   o_pc_start_addr     - PC start address
//   o_start             - one-cycle release pulse
//   o_err               - sticky protocol error
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_setup,
  output logic        o_inst_mem_we,
  output logic [31:0] o_inst_mem_addr,
  output logic [31:0] o_inst_mem_data,
  output logic        o_load_reg_we,
  output logic [4:0]  o_load_reg_addr,
  output logic [31:0] o_load_reg_data,
  output logic [31:0] o_pc_start_addr,
  output logic        o_start,
  output logic        o_err
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  logic [3:0]  state;
  logic [31:0] addr;
  logic [15:0] remaining;
  logic [7:0]  count_lo;
  logic        count_idx;
  logic [4:0]  reg_sel;
  logic [31:0] inst_addr_q, inst_data_q;
  logic        reg_we_q;
  logic [4:0]  reg_addr_q;
  logic [31:0] reg_data_q, pc_q;
  logic        start_q, setup_q;

  logic        take;
  logic        asm_en, word_done;
  logic [31:0] next_word;

  assign o_byte_ready = (state != ST_WRITE) && (state != ST_DONE);
  assign take         = i_byte_valid && o_byte_ready;

  assign asm_en = take && ((state == ST_ADDR) || (state == ST_DATA) ||
                           (state == ST_REG_DATA) || (state == ST_START_ADDR));

  boot_loader_byte_to_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_en   (asm_en),
    .byte_data (i_byte_data),
    .word_done (word_done),
    .next_word (next_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr        <= '0;
      remaining   <= '0;
      count_lo    <= '0;
      count_idx   <= 1'b0;
      reg_sel     <= '0;
      inst_addr_q <= '0;
      inst_data_q <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      pc_q        <= '0;
      start_q     <= 1'b0;
      setup_q     <= 1'b1;
    end else begin
      // NOTE: strobes default low every cycle so each assignment below
      // produces exactly a one-cycle pulse.
      reg_we_q <= 1'b0;
      start_q  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (take) begin
            case (i_byte_data)
              CMD_LOAD_INST: state <= ST_ADDR;
              CMD_LOAD_REG:  state <= ST_REG_ADDR;
              CMD_START:     state <= ST_START_ADDR;
              default:       state <= ST_ERR;
            endcase
          end
        end

        ST_ADDR: begin
          if (word_done) begin
            addr <= next_word;
            if ((next_word[1:0] != 2'b00) || (next_word >= IMEM_BYTES))
              state <= ST_ERR;
            else
              state <= ST_COUNT;
          end
        end

        ST_COUNT: begin
          if (take) begin
            if (count_idx != 1'(FIELD_COUNT_BYTES - 1)) begin
              count_lo  <= i_byte_data;
              count_idx <= 1'b1;
            end else begin
              count_idx <= 1'b0;
              remaining <= {i_byte_data, count_lo};
              state     <= ({i_byte_data, count_lo} == 16'd0) ? ST_IDLE : ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (word_done) begin
            // Capture into output registers so the bus holds this write's
            // address even after addr advances.
            inst_addr_q <= addr;
            inst_data_q <= next_word;
            state       <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          // addr is below IMEM_BYTES here, so addr+4 cannot wrap.
          addr      <= addr + 32'd4;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1)
            state <= ST_IDLE;
          else if ((addr + 32'd4) >= IMEM_BYTES)
            state <= ST_ERR;
          else
            state <= ST_DATA;
        end

        ST_REG_ADDR: begin
          if (take) begin
            reg_sel <= i_byte_data[4:0];
            state   <= ST_REG_DATA;
          end
        end

        ST_REG_DATA: begin
          if (word_done) begin
            // x0 is hardwired: the frame is accepted but writes nothing.
            if (reg_sel != 5'd0) begin
              reg_we_q   <= 1'b1;
              reg_addr_q <= reg_sel;
              reg_data_q <= next_word;
            end
            state <= ST_IDLE;
          end
        end

        ST_START_ADDR: begin
          if (word_done) begin
            if (next_word[1:0] != 2'b00) begin
              state <= ST_ERR;
            end else begin
              pc_q    <= next_word;
              setup_q <= 1'b0;
              start_q <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end

        ST_DONE: state <= ST_DONE;
        ST_ERR:  state <= ST_ERR;
        default: state <= ST_ERR;
      endcase
    end
  end

  assign o_setup         = setup_q;
  assign o_inst_mem_we   = (state == ST_WRITE);
  assign o_inst_mem_addr = inst_addr_q;
  assign o_inst_mem_data = inst_data_q;
  assign o_load_reg_we   = reg_we_q;
  assign o_load_reg_addr = reg_addr_q;
  assign o_load_reg_data = reg_data_q;
  assign o_pc_start_addr = pc_q;
  assign o_start         = start_q;
  assign o_err           = (state == ST_ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader. A full-size instance and a 4-word
// instance share the byte link; 'target' selects which one receives bytes.
// Expected write/preload/start events are queued before stimulus and
// popped by negedge monitors when the DUT strobes.
module tb_boot_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_byte_valid = 1'b0;
  logic [7:0] i_byte_data = 8'h00;
  logic       target = 1'b0;  // 0: big DUT, 1: small DUT

  always #5 clk = ~clk;

  logic        b_ready, b_setup, b_inst_we, b_reg_we, b_start, b_err;
  logic [31:0] b_inst_addr, b_inst_data, b_reg_data, b_pc;
  logic [4:0]  b_reg_addr;
  logic        s_ready, s_setup, s_inst_we, s_reg_we, s_start, s_err;
  logic [31:0] s_inst_addr, s_inst_data, s_reg_data, s_pc;
  logic [4:0]  s_reg_addr;

  boot_loader #(.IMEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_byte_valid(i_byte_valid && !target), .i_byte_data(i_byte_data),
    .o_byte_ready(b_ready), .o_setup(b_setup),
    .o_inst_mem_we(b_inst_we), .o_inst_mem_addr(b_inst_addr), .o_inst_mem_data(b_inst_data),
    .o_load_reg_we(b_reg_we), .o_load_reg_addr(b_reg_addr), .o_load_reg_data(b_reg_data),
    .o_pc_start_addr(b_pc), .o_start(b_start), .o_err(b_err)
  );

  boot_loader #(.IMEM_WORDS(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .i_byte_valid(i_byte_valid && target), .i_byte_data(i_byte_data),
    .o_byte_ready(s_ready), .o_setup(s_setup),
    .o_inst_mem_we(s_inst_we), .o_inst_mem_addr(s_inst_addr), .o_inst_mem_data(s_inst_data),
    .o_load_reg_we(s_reg_we), .o_load_reg_addr(s_reg_addr), .o_load_reg_data(s_reg_data),
    .o_pc_start_addr(s_pc), .o_start(s_start), .o_err(s_err)
  );

  wire        m_ready     = target ? s_ready     : b_ready;
  wire        m_inst_we   = target ? s_inst_we   : b_inst_we;
  wire [31:0] m_inst_addr = target ? s_inst_addr : b_inst_addr;
  wire [31:0] m_inst_data = target ? s_inst_data : b_inst_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_inst[$];  // {addr, data}
  logic [36:0] exp_reg[$];   // {reg, data}
  int          exp_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && m_inst_we) begin
      if (exp_inst.size() == 0) begin
        check("unexpected_inst_we", m_inst_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_inst.pop_front();
        check("inst_addr", m_inst_addr, e[63:32]);
        check("inst_data", m_inst_data, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_reg_we) begin
      if (exp_reg.size() == 0) begin
        check("unexpected_reg_we", 32'(b_reg_addr), 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = exp_reg.pop_front();
        check("reg_addr", 32'(b_reg_addr), 32'(e[36:32]));
        check("reg_data", b_reg_data, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_start) begin
      if (exp_start == 0) begin
        check("unexpected_start", 32'(b_start), 32'd0);
      end else begin
        exp_start--;
        check("start_pc", b_pc, 32'h0000_0200);
        check("start_setup", 32'(b_setup), 32'd0);
      end
    end
  end

  // Present one byte and hold it until the selected DUT takes it.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    while (!m_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
    i_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_ready"},     32'(b_ready),     32'd1);
    check({pfx, "_setup"},     32'(b_setup),     32'd1);
    check({pfx, "_err"},       32'(b_err),       32'd0);
    check({pfx, "_inst_we"},   32'(b_inst_we),   32'd0);
    check({pfx, "_inst_addr"}, b_inst_addr,      32'd0);
    check({pfx, "_inst_data"}, b_inst_data,      32'd0);
    check({pfx, "_reg_we"},    32'(b_reg_we),    32'd0);
    check({pfx, "_reg_addr"},  32'(b_reg_addr),  32'd0);
    check({pfx, "_reg_data"},  b_reg_data,       32'd0);
    check({pfx, "_pc"},        b_pc,             32'd0);
    check({pfx, "_start"},     32'(b_start),     32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, checked while held low.
  task automatic do_reset(input string pfx);
    i_byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_values(pfx);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    do_reset("rst0");

    // LOAD_INST: two words at 0x100
    exp_inst.push_back({32'h0000_0100, 32'h0000_0013});
    exp_inst.push_back({32'h0000_0104, 32'h0010_0093});
    send_seq('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
    idle(3);
    check("inst_pending", 32'(exp_inst.size()), 32'd0);
    check("load_setup", 32'(b_setup), 32'd1);
    check("load_err", 32'(b_err), 32'd0);

    // LOAD_REG to x5, then to x0 (no strobe, no error)
    exp_reg.push_back({5'd5, 32'h1234_5678});
    send_seq('{8'h5A, 8'h05, 8'h78, 8'h56, 8'h34, 8'h12});
    send_seq('{8'h5A, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
    idle(3);
    check("reg_pending", 32'(exp_reg.size()), 32'd0);
    check("reg_hold_addr", 32'(b_reg_addr), 32'd5);
    check("reg_hold_data", b_reg_data, 32'h1234_5678);
    check("reg_x0_err", 32'(b_err), 32'd0);

    // START at 0x200, then input is refused
    exp_start = 1;
    send_seq('{8'hC3, 8'h00, 8'h02, 8'h00, 8'h00});
    idle(3);
    check("start_pending", 32'(exp_start), 32'd0);
    check("done_pc", b_pc, 32'h0000_0200);
    check("done_setup", 32'(b_setup), 32'd0);
    i_byte_valid = 1'b1;
    i_byte_data  = 8'hA5;
    @(negedge clk);
    check("done_ready", 32'(b_ready), 32'd0);
    idle(3);
    check("done_ready_hold", 32'(b_ready), 32'd0);

    // Unknown command -> sticky error, later START discarded
    do_reset("rst1");
    send_seq('{8'h11});
    idle(2);
    check("unk_err", 32'(b_err), 32'd1);
    check("unk_setup", 32'(b_setup), 32'd1);
    send_seq('{8'hC3, 8'h00, 8'h02, 8'h00, 8'h00});
    idle(3);
    check("unk_err_sticky", 32'(b_err), 32'd1);
    check("unk_setup_hold", 32'(b_setup), 32'd1);
    check("unk_pc", b_pc, 32'd0);
    check("unk_ready", 32'(b_ready), 32'd1);

    // Misaligned LOAD_INST address
    do_reset("rst2");
    send_seq('{8'hA5, 8'h02, 8'h01, 8'h00});
    idle(1);
    check("misalign_err_early", 32'(b_err), 32'd0);
    send_seq('{8'h00});
    idle(1);
    check("misalign_err", 32'(b_err), 32'd1);

    // 4-word memory: addr 0x8, count 3 -> writes at 0x8 and 0xC, then error
    do_reset("rst3");
    target = 1'b1;
    exp_inst.push_back({32'h0000_0008, 32'hAAAA_0001});
    exp_inst.push_back({32'h0000_000C, 32'hAAAA_0002});
    send_seq('{8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00,
               8'h01, 8'h00, 8'hAA, 8'hAA, 8'h02, 8'h00, 8'hAA, 8'hAA,
               8'h03, 8'h00, 8'hAA, 8'hAA});
    idle(3);
    check("small_pending", 32'(exp_inst.size()), 32'd0);
    check("small_err", 32'(s_err), 32'd1);
    check("small_setup", 32'(s_setup), 32'd1);
    check("small_idle_outs",
          32'({s_reg_we, s_start, |s_pc, |s_reg_addr, |s_reg_data}), 32'd0);
    target = 1'b0;

    // Reset mid-DATA, then a fresh frame
    do_reset("rst4");
    send_seq('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h0D, 8'hF0});
    do_reset("rst_mid");
    exp_inst.push_back({32'h0000_0010, 32'hCAFE_F00D});
    send_seq('{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
               8'h0D, 8'hF0, 8'hFE, 8'hCA});
    idle(3);
    check("fresh_pending", 32'(exp_inst.size()), 32'd0);
    check("fresh_err", 32'(b_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
Byte-stream boot loader that acts as the transmitter for the core's setup/load interface.
- Receives framed commands on a valid/ready byte input, typically from a UART receiver.
- Assembles little-endian words and drives instruction-memory writes, register preloads and the PC start address.
- Holds the core in setup until a START frame releases it.
- Sits between the host link and the core top-level in the SoC wrapper.

Parameters:
CMD_LOAD_INST, 8'hA5, opcode of an instruction-block load frame
CMD_LOAD_REG, 8'h5A, opcode of a register preload frame
CMD_START, 8'hC3, opcode of the start frame
IMEM_WORDS, 1024, instruction memory depth in words; the legal byte range is 0 to IMEM_WORDS*4-1

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset
i_byte_valid  input  1  input byte is valid
i_byte_data  input  8  input byte
o_byte_ready  output  1  loader accepts a byte this cycle
o_setup  output  1  core is held in setup/load mode
o_inst_mem_we  output  1  one-cycle instruction-memory write strobe
o_inst_mem_addr  output  32  instruction-memory byte address
o_inst_mem_data  output  32  instruction word to write
o_load_reg_we  output  1  one-cycle register-load strobe
o_load_reg_addr  output  5  destination register
o_load_reg_data  output  32  register value
o_pc_start_addr  output  32  PC start address presented to the core
o_start  output  1  one-cycle pulse when the core is released
o_err  output  1  sticky protocol error

Behaviour:
- Reset values (asynchronous on rst_n low, any state, mid-frame included):
  - o_setup=1, o_byte_ready=1, o_err=0; all other outputs 0.
  - State=IDLE; the partial frame is discarded.
- A byte is consumed only on a cycle with i_byte_valid && o_byte_ready.
- o_byte_ready=1 in every state except WRITE and DONE.
- Frame formats; multi-byte fields are little-endian, LSB first:
  - LOAD_INST: cmd, addr[4 bytes], count[2 bytes], then count x 4 data bytes.
  - LOAD_REG: cmd, reg[1 byte; bits 4:0 used, bits 7:5 ignored], data[4 bytes].
  - START: cmd, addr[4 bytes].
- States: IDLE, ADDR, COUNT, DATA, WRITE, REG_ADDR, REG_DATA, START_ADDR, DONE, ERR.
- IDLE transitions:
  - CMD_LOAD_INST -> ADDR.
  - CMD_LOAD_REG -> REG_ADDR.
  - CMD_START -> START_ADDR.
  - Any other byte -> ERR.
- ADDR: collects 4 bytes, then goes to COUNT. If addr[1:0]!=0 or addr>=IMEM_WORDS*4, go to ERR after the 4th byte.
- COUNT: collects 2 bytes.
  - count==0 -> IDLE with no writes.
  - count>0 -> DATA.
- DATA: collects 4 bytes into a word, then goes to WRITE.
- WRITE lasts exactly one cycle:
  - o_inst_mem_we=1 with the current addr/data.
  - addr += 4; remaining -= 1.
  - remaining==0 -> IDLE; otherwise -> DATA.
  - If the incremented addr reaches IMEM_WORDS*4 while remaining>0, go to ERR instead. Words already written stay written.
- Throughput: one byte per cycle in all receive states. Each word costs 5 cycles (4 bytes plus the WRITE cycle).
- REG_DATA after its 4th byte:
  - reg!=0: o_load_reg_we pulses for one cycle on the next cycle; addr and data are held stable. Then -> IDLE.
  - reg==0: no strobe; -> IDLE with no error.
- START_ADDR after its 4th byte:
  - addr[1:0]!=0 -> ERR.
  - Otherwise, on the next cycle: o_pc_start_addr=addr, o_setup=0, o_start pulses for one cycle; -> DONE.
- DONE: o_byte_ready=0; all input is ignored until reset. o_pc_start_addr is held.
- ERR: o_err=1 (sticky), o_setup stays 1, o_byte_ready=1, and bytes are consumed and discarded. Exit is by reset only.
- Data outputs (addr/data buses) hold their last values when their strobe is low.
- Counters: byte index is 2 bits, remaining word count is 16 bits, address adder is 32 bits with no wrap (range-checked first).

Decomposition:
- The shared globals include file holds: command opcode constants, the state encoding, and the frame field lengths.
- One natural sub-module: byte_to_word_assembler. It is a 2-bit index plus a 32-bit shift register with a word_done pulse. The ADDR, DATA, REG_DATA and START_ADDR states reuse it.

Test Plan:
- Reset, then bytes A5 00 01 00 00 02 00 13 00 00 00 93 00 10 00 -> two o_inst_mem_we pulses: addr 0x100/data 0x00000013, then 0x104/0x00100093. o_setup stays 1.
- 5A 05 78 56 34 12 -> one o_load_reg_we pulse, reg 5, data 0x12345678. Then 5A 00 FF FF FF FF -> no strobe and o_err=0.
- C3 00 02 00 00 -> o_pc_start_addr=0x200, o_start pulses once, o_setup=0. A following byte 0xA5 is not accepted (o_byte_ready=0).
- Unknown cmd 0x11 -> o_err=1, o_setup=1. A later valid START frame is discarded and o_start never pulses.
- LOAD_INST with addr 0x102 -> ERR after the 4th address byte. Separately, IMEM_WORDS=4, addr 0x8, count 3 -> two writes (0x8, 0xC), then ERR.
- rst_n asserted low mid-DATA (after 2 of 4 bytes) -> no write strobe and outputs at reset values. After release, a fresh frame works normally.
